sand_row_stepper: RTL and testbench

Parametrised, clocked successor to the combinational sand region/floor updater. It buffers one full screen row of packed 2-bit cells (a region row and the floor row beneath it) and performs one physics step over the whole row with a left-to-right sequential scan, with correct neighbour handling across word boundaries. It streams the updated row out with valid/ready flow control. It sits between the framebuffer row reader and the row writer in the simulation loop.

---
 rtl/sand_row_stepper.sv | 164 ++++++++++++++++
 tb/tb_sand_row_stepper.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sand_row_stepper.sv
// Row-buffered sand physics stepper: loads one row of region/floor words,
// scans it left to right one word per cycle, then streams the result out.
module sand_row_stepper #(
    parameter int CELLS     = 16,
    parameter int ROW_WORDS = 40
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*CELLS-1:0]   region,
    input  logic [2*CELLS-1:0]   floor,
    input  logic                 frame_parity,
    input  logic                 enable,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*CELLS-1:0]   new_region,
    output logic [2*CELLS-1:0]   new_floor,
    output logic                 out_last,
    output logic                 busy
);

    localparam int W  = 2 * CELLS;
    localparam int CW = $clog2(ROW_WORDS);
    localparam logic [CW-1:0] LAST = CW'(ROW_WORDS - 1);

    localparam logic [1:0] AIR     = 2'b00;
    localparam logic [1:0] SAND    = 2'b01;
    localparam logic [1:0] SAND_AM = 2'b10;
    localparam logic [1:0] WALL    = 2'b11;

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] w_q, w_d;
    logic          pref_q;
    logic          en_q;
    logic [W-1:0]  region_q [ROW_WORDS];
    logic [W-1:0]  floor_q  [ROW_WORDS];

    logic [CW-1:0] wp1, wm1;
    logic          in_fire;
    logic [1:0]    fx [CELLS+2];
    logic [W-1:0]  rx, fw;
    logic          px;

    assign wp1      = w_q + CW'(1);
    assign wm1      = w_q - CW'(1);
    assign in_ready = !reset && (state_q == IDLE || state_q == LOAD);
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_fire) begin
                    state_d = LOAD;
                    w_d     = wp1;
                end
            end
            LOAD: begin
                if (in_fire) begin
                    if (w_q == LAST) begin
                        state_d = SCAN;
                        w_d     = '0;
                    end else begin
                        w_d = wp1;
                    end
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (w_q == LAST) begin
                    state_d = DRAIN;
                    w_d     = '0;
                end else begin
                    w_d = wp1;
                end
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    if (w_q == LAST) begin
                        state_d = IDLE;
                        w_d     = '0;
                    end else begin
                        w_d = wp1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // fx[0] is the right neighbour floor cell, fx[CELLS+1] the left one.
    always_comb begin
        rx = region_q[w_q];
        px = pref_q;
        for (int k = 0; k < CELLS; k++) fx[k+1] = floor_q[w_q][2*k +: 2];
        fx[0]       = WALL;
        fx[CELLS+1] = WALL;
        if (w_q != LAST) fx[0] = floor_q[wp1][W-1 -: 2];
        if (w_q != '0) fx[CELLS+1] = floor_q[wm1][1:0];
        for (int i = CELLS - 1; i >= 0; i--) begin
            if (rx[2*i +: 2] == SAND_AM) begin
                rx[2*i +: 2] = SAND;
            end else if (rx[2*i +: 2] == SAND) begin
                if (fx[i+1] == AIR) begin
                    rx[2*i +: 2] = AIR;
                    fx[i+1]      = SAND_AM;
                end else if (fx[i+2] == AIR && fx[i] == AIR) begin
                    rx[2*i +: 2] = AIR;
                    if (px) fx[i] = SAND_AM;
                    else fx[i+2] = SAND_AM;
                    px = ~px;
                end else if (fx[i+2] == AIR) begin
                    rx[2*i +: 2] = AIR;
                    fx[i+2]      = SAND_AM;
                end else if (fx[i] == AIR) begin
                    rx[2*i +: 2] = AIR;
                    fx[i]        = SAND_AM;
                end
            end
        end
        fw = '0;
        for (int k = 0; k < CELLS; k++) fw[2*k +: 2] = fx[k+1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            w_q     <= '0;
            pref_q  <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            if (in_fire) begin
                region_q[w_q] <= region;
                floor_q[w_q]  <= floor;
            end
            if (in_fire && state_q == IDLE) begin
                pref_q <= frame_parity;
                en_q   <= enable;
            end
            if (state_q == SCAN && en_q) begin
                region_q[w_q] <= rx;
                floor_q[w_q]  <= fw;
                if (w_q != '0) floor_q[wm1][1:0] <= fx[CELLS+1];
                if (w_q != LAST) floor_q[wp1][W-1 -: 2] <= fx[0];
                pref_q <= px;
            end
        end
    end

    assign new_region = (state_q == DRAIN) ? region_q[w_q] : '0;
    assign new_floor  = (state_q == DRAIN) ? floor_q[w_q] : '0;
    assign out_last   = (state_q == DRAIN) && (w_q == LAST);

endmodule

// File: tb/tb_sand_row_stepper.sv
// Scoreboard bench for sand_row_stepper with CELLS=4, ROW_WORDS=2.
module tb_sand_row_stepper;

    localparam int C  = 4;
    localparam int RW = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] region = '0;
    logic [7:0] floor = '0;
    logic       frame_parity = 1'b0;
    logic       enable = 1'b1;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] new_region;
    logic [7:0] new_floor;
    logic       out_last;
    logic       busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] f;
        logic       last;
    } exp_t;

    exp_t sb[$];

    sand_row_stepper #(.CELLS(C), .ROW_WORDS(RW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .region(region), .floor(floor),
        .frame_parity(frame_parity), .enable(enable),
        .out_valid(out_valid), .out_ready(out_ready),
        .new_region(new_region), .new_floor(new_floor),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Reference: whole row as 8 cells, cell 0 leftmost at bits [15:14].
    function automatic logic [31:0] model(input logic [15:0] r,
                                          input logic [15:0] f,
                                          input logic par,
                                          input logic en);
        logic [1:0] rc [8];
        logic [1:0] fc [8];
        logic [15:0] ro, fo;
        logic p;
        for (int g = 0; g < 8; g++) begin
            rc[g] = r[15-2*g -: 2];
            fc[g] = f[15-2*g -: 2];
        end
        p = par;
        if (en) begin
            for (int g = 0; g < 8; g++) begin
                logic [1:0] dl, dr;
                dl = (g == 0) ? 2'b11 : fc[g-1];
                dr = (g == 7) ? 2'b11 : fc[g+1];
                if (rc[g] == 2'b10) begin
                    rc[g] = 2'b01;
                end else if (rc[g] == 2'b01) begin
                    if (fc[g] == 2'b00) begin
                        rc[g] = 2'b00;
                        fc[g] = 2'b10;
                    end else if (dl == 2'b00 && dr == 2'b00) begin
                        rc[g] = 2'b00;
                        if (!p) fc[g-1] = 2'b10;
                        else fc[g+1] = 2'b10;
                        p = !p;
                    end else if (dl == 2'b00) begin
                        rc[g] = 2'b00;
                        fc[g-1] = 2'b10;
                    end else if (dr == 2'b00) begin
                        rc[g] = 2'b00;
                        fc[g+1] = 2'b10;
                    end
                end
            end
        end
        for (int g = 0; g < 8; g++) begin
            ro[15-2*g -: 2] = rc[g];
            fo[15-2*g -: 2] = fc[g];
        end
        return {ro, fo};
    endfunction

    task automatic push_row(input logic [15:0] er, input logic [15:0] ef);
        sb.push_back(exp_t'({er[15:8], ef[15:8], 1'b0}));
        sb.push_back(exp_t'({er[7:0], ef[7:0], 1'b1}));
    endtask

    task automatic send_word(input logic [7:0] r, input logic [7:0] f,
                             input logic par, input logic en);
        int n;
        n = 0;
        region = r;
        floor = f;
        frame_parity = par;
        enable = en;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL in_accept: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_row(input logic [15:0] r, input logic [15:0] f,
                            input logic par, input logic en);
        send_word(r[15:8], f[15:8], par, en);
        send_word(r[7:0], f[7:0], par, en);
    endtask

    // Called right after send_row: first negedge falls in the first SCAN cycle.
    task automatic wait_valid(input string name);
        int lat;
        @(negedge clk);
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != RW + 1) begin
            errors++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, RW + 1);
        end
    endtask

    task automatic receive(input string name);
        int got, n;
        exp_t e;
        got = 0;
        n = 0;
        out_ready = 1'b1;
        while (got < RW && n < 50) begin
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL %s unexpected word r=%h f=%h", name, new_region, new_floor);
                end else begin
                    e = sb.pop_front();
                    if (new_region !== e.r || new_floor !== e.f || out_last !== e.last) begin
                        errors++;
                        $display("FAIL %s word%0d: got r=%h f=%h last=%b required r=%h f=%h last=%b",
                                 name, got, new_region, new_floor, out_last, e.r, e.f, e.last);
                    end
                end
                got++;
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (got != RW || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s end: words=%0d out_valid=%b in_ready=%b required %0d 0 1",
                     name, got, out_valid, in_ready, RW);
        end
        sb.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic run_case(input string name, input logic [15:0] r, input logic [15:0] f,
                            input logic par, input logic en,
                            input logic [15:0] er, input logic [15:0] ef);
        push_row(er, ef);
        send_row(r, f, par, en);
        wait_valid(name);
        receive(name);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: in_ready=%b out_valid=%b busy=%b last=%b required 0 0 0 0",
                     in_ready, out_valid, busy, out_last);
        end
        checks++;
        if (new_region !== 8'h00 || new_floor !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: r=%h f=%h required 00 00", new_region, new_floor);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_physics;
        run_case("straight", 16'h4000, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h8000);
        run_case("edge_diag", 16'h4000, 16'hC000, 1'b0, 1'b1, 16'h0000, 16'hE000);
        run_case("pref0", 16'h1000, 16'h3000, 1'b0, 1'b1, 16'h0000, 16'hB000);
        run_case("pref1", 16'h1000, 16'h3000, 1'b1, 1'b1, 16'h0000, 16'h3800);
        run_case("cross_word", 16'h0100, 16'h0F00, 1'b0, 1'b1, 16'h0000, 16'h0F80);
        run_case("settle", 16'hAA00, 16'h0000, 1'b0, 1'b1, 16'h5500, 16'h0000);
        run_case("passthru", 16'h4455, 16'h0C30, 1'b1, 1'b0, 16'h4455, 16'h0C30);
        // Two diagonal choices in different words: preference carries over.
        run_case("pref_carry", 16'h1010, 16'h3030, 1'b0, 1'b1, 16'h0000, 16'hB038);
    endtask

    task automatic test_random;
        logic [15:0] r, f;
        logic par, en;
        logic [31:0] e;
        for (int k = 0; k < 10; k++) begin
            r = 16'($urandom);
            f = 16'($urandom);
            par = 1'($urandom_range(0, 1));
            en = (k != 9);
            e = model(r, f, par, en);
            run_case("random", r, f, par, en, e[31:16], e[15:0]);
        end
    endtask

    task automatic test_flow_control;
        push_row(16'h5500, 16'h0000);
        send_row(16'hAA00, 16'h0000, 1'b0, 1'b1);
        out_ready = 1'b0;
        wait_valid("stall");
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (out_valid !== 1'b1 || new_region !== 8'h55 || new_floor !== 8'h00 || out_last !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: v=%b r=%h f=%h last=%b required 1 55 00 0",
                         k, out_valid, new_region, new_floor, out_last);
            end
            @(negedge clk);
        end
        receive("stall");
    endtask

    task automatic test_reset_mid_drain;
        send_row(16'h4000, 16'h0000, 1'b0, 1'b1);
        wait_valid("mid_reset");
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: out_valid=%b in_ready=%b busy=%b required 0 1 0",
                     out_valid, in_ready, busy);
        end
        sb.delete();
        @(posedge clk);
        #1;
        run_case("after_reset", 16'h1000, 16'h3000, 1'b1, 1'b1, 16'h0000, 16'h3800);
    endtask

    task automatic test_back_to_back;
        run_case("b2b_a", 16'h4000, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h8000);
        run_case("b2b_b", 16'h0100, 16'h0F00, 1'b0, 1'b1, 16'h0000, 16'h0F80);
    endtask

    initial begin
        test_reset;
        test_physics;
        test_random;
        test_flow_control;
        test_reset_mid_drain;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
